// File: rtl/demux_serializer_if.sv
// Word-in / serial-out bundle for demux_serializer: a valid/ready word port on
// one side, and on the other the bit/select pair that feeds a downstream 1-to-4 demux.
interface demux_serializer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_chan;
    logic              ser_i;
    logic [1:0]        ser_s;
    logic              ser_en;
    logic              busy;
    logic              frame_done;
    logic [7:0]        frame_cnt;

    modport master (
        output in_valid, in_data, in_chan,
        input  in_ready, ser_i, ser_s, ser_en, busy, frame_done, frame_cnt
    );

    modport slave (
        input  in_valid, in_data, in_chan,
        output in_ready, ser_i, ser_s, ser_en, busy, frame_done, frame_cnt
    );
endinterface

// File: rtl/demux_serializer.sv
// Serializes one DATA_W word at a time, MSB first, onto ser_i with a channel
// select held on ser_s for the whole frame, followed by GAP_CYCLES idle cycles.
module demux_serializer #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    demux_serializer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DATA_W - 2);
    localparam logic [3:0]       GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [1:0]        chan_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [3:0]        gap_cnt_reg;
    logic              ser_en_reg;
    logic              frame_done_reg;
    logic [7:0]        frame_cnt_reg;

    // The shift register zero-fills, so its MSB is already 0 once the frame
    // has been shifted out; ser_i needs no extra gating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            chan_reg       <= 2'd0;
            bit_cnt_reg    <= '0;
            gap_cnt_reg    <= 4'd0;
            ser_en_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= 8'd0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg   <= SHIFT;
                        shift_reg   <= bus.in_data;
                        chan_reg    <= bus.in_chan;
                        bit_cnt_reg <= '0;
                        ser_en_reg  <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        ser_en_reg    <= 1'b0;
                        frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        gap_cnt_reg   <= 4'd0;
                        state_reg     <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        bit_cnt_reg    <= bit_cnt_reg + 1'b1;
                        frame_done_reg <= (bit_cnt_reg == PRE_LAST);
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    shift_reg  <= '0;
                    ser_en_reg <= 1'b0;
                end
            endcase
        end
    end

    // in_ready is gated by rst directly so no word is accepted while reset is held.
    assign bus.in_ready   = (state_reg == IDLE) && !rst;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.ser_i      = shift_reg[DATA_W-1];
    assign bus.ser_s      = chan_reg;
    assign bus.ser_en     = ser_en_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.frame_cnt  = frame_cnt_reg;
endmodule

// File: tb/tb_demux_serializer.sv
// Directed bench for demux_serializer: default build (GAP_CYCLES=1) on ifa and
// a GAP_CYCLES=0 build on ifb, both sharing clk and rst.
module tb_demux_serializer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_pulses = 0;
    logic [7:0] exp_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    demux_serializer_if #(.DATA_W(8)) ifa ();
    demux_serializer_if #(.DATA_W(8)) ifb ();

    demux_serializer #(.DATA_W(8), .GAP_CYCLES(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    demux_serializer #(.DATA_W(8), .GAP_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    always @(negedge clk) if (ifa.frame_done) done_pulses++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one word on ifa and checks every bit of the frame plus the gap cycle.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] c,
                             input bit hold, input bit scramble, output int acc);
        int waited = 0;
        @(negedge clk);
        ifa.in_valid = 1'b1;
        ifa.in_data  = d;
        ifa.in_chan  = c;
        while (!ifa.in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_val("in_ready_wait", {31'd0, ifa.in_ready}, 32'd1);
        acc = cyc;
        @(negedge clk);
        if (!hold) ifa.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val("ser_en",        {31'd0, ifa.ser_en},     32'd1);
            check_val("ser_i",         {31'd0, ifa.ser_i},      {31'd0, d[7-i]});
            check_val("ser_s",         {30'd0, ifa.ser_s},      {30'd0, c});
            check_val("frame_done",    {31'd0, ifa.frame_done}, (i == 7) ? 32'd1 : 32'd0);
            check_val("frame_cnt_mid", {24'd0, ifa.frame_cnt},  {24'd0, exp_cnt});
            check_val("in_ready_busy", {31'd0, ifa.in_ready},   32'd0);
            if (scramble) begin
                ifa.in_data = 8'($urandom);
                ifa.in_chan = 2'($urandom);
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 8'd1;
        check_val("gap_ser_en",     {31'd0, ifa.ser_en},     32'd0);
        check_val("gap_ser_i",      {31'd0, ifa.ser_i},      32'd0);
        check_val("gap_frame_done", {31'd0, ifa.frame_done}, 32'd0);
        check_val("gap_busy",       {31'd0, ifa.busy},       32'd1);
        check_val("gap_in_ready",   {31'd0, ifa.in_ready},   32'd0);
        check_val("gap_ser_s",      {30'd0, ifa.ser_s},      {30'd0, c});
        check_val("frame_cnt_end",  {24'd0, ifa.frame_cnt},  {24'd0, exp_cnt});
        $display("frame data=%h chan=%0d accept_cyc=%0d frame_cnt=%0d", d, c, acc, ifa.frame_cnt);
    endtask

    initial begin
        int acc, prev, pulses0, na, low_run;
        int acc_b[8];
        bit seen_high;
        logic [7:0] words[4];
        words[0] = 8'h5A; words[1] = 8'hC3; words[2] = 8'h0F; words[3] = 8'hF0;

        rst = 1'b1;
        ifa.in_valid = 1'b1; ifa.in_data = 8'hFF; ifa.in_chan = 2'd3;
        ifb.in_valid = 1'b0; ifb.in_data = 8'h00; ifb.in_chan = 2'd0;
        exp_cnt = 8'd0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready",   {31'd0, ifa.in_ready},   32'd0);
        check_val("rst_ser_i",      {31'd0, ifa.ser_i},      32'd0);
        check_val("rst_ser_s",      {30'd0, ifa.ser_s},      32'd0);
        check_val("rst_ser_en",     {31'd0, ifa.ser_en},     32'd0);
        check_val("rst_busy",       {31'd0, ifa.busy},       32'd0);
        check_val("rst_frame_done", {31'd0, ifa.frame_done}, 32'd0);
        check_val("rst_frame_cnt",  {24'd0, ifa.frame_cnt},  32'd0);
        check_val("rst_b_busy",     {31'd0, ifb.busy},       32'd0);
        ifa.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_val("post_rst_in_ready", {31'd0, ifa.in_ready}, 32'd1);

        // Reset during the 4th bit drops the frame without counting it.
        @(negedge clk);
        ifa.in_valid = 1'b1; ifa.in_data = 8'h3C; ifa.in_chan = 2'd1;
        @(negedge clk);
        ifa.in_valid = 1'b0;
        check_val("abort_ser_en_bit0", {31'd0, ifa.ser_en}, 32'd1);
        repeat (3) @(negedge clk);
        check_val("abort_ser_s_bit3", {30'd0, ifa.ser_s}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("abort_ser_en",     {31'd0, ifa.ser_en},     32'd0);
        check_val("abort_ser_i",      {31'd0, ifa.ser_i},      32'd0);
        check_val("abort_ser_s",      {30'd0, ifa.ser_s},      32'd0);
        check_val("abort_busy",       {31'd0, ifa.busy},       32'd0);
        check_val("abort_in_ready",   {31'd0, ifa.in_ready},   32'd0);
        check_val("abort_frame_done", {31'd0, ifa.frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        check_val("abort_frame_cnt",  {24'd0, ifa.frame_cnt},  32'd0);
        check_val("abort_pulses",     32'(done_pulses),        32'd0);
        rst = 1'b0;

        run_frame(8'hA5, 2'd2, 1'b0, 1'b0, acc);
        check_val("a5_pulses", 32'(done_pulses), 32'd1);

        // in_valid held high: accepts every DATA_W+GAP+1 = 10 cycles.
        for (int k = 0; k < 4; k++) begin
            prev = acc;
            run_frame(words[k], 2'(k), 1'b1, 1'b0, acc);
            if (k > 0) check_val("accept_period", 32'(acc - prev), 32'd10);
        end
        ifa.in_valid = 1'b0;
        check_val("held_frame_cnt", {24'd0, ifa.frame_cnt}, 32'd5);

        run_frame(8'h96, 2'd3, 1'b0, 1'b1, acc);
        run_frame(8'h01, 2'd1, 1'b1, 1'b1, acc);
        ifa.in_valid = 1'b0;

        // GAP_CYCLES=0 build: accepts every 9 cycles, ser_en low 1 cycle between frames.
        na = 0; low_run = 0; seen_high = 1'b0;
        @(negedge clk);
        ifb.in_valid = 1'b1; ifb.in_data = 8'h81; ifb.in_chan = 2'd3;
        for (int n = 0; n < 40; n++) begin
            if (ifb.in_ready && na < 8) begin
                acc_b[na] = cyc;
                na++;
            end
            if (ifb.ser_en) begin
                check_val("b_ser_s", {30'd0, ifb.ser_s}, 32'd3);
                if (low_run > 0) check_val("b_low_run", 32'(low_run), 32'd1);
                low_run = 0;
                seen_high = 1'b1;
            end else if (seen_high) begin
                low_run++;
            end
            @(negedge clk);
        end
        ifb.in_valid = 1'b0;
        check_val("b_accepts_ge4", {31'd0, (na >= 4)}, 32'd1);
        for (int n = 1; n < 4; n++) check_val("b_accept_period", 32'(acc_b[n] - acc_b[n-1]), 32'd9);

        // 257 frames from reset: frame_cnt wraps through 0 to 1.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;
        pulses0 = done_pulses;
        for (int n = 0; n < 257; n++) begin
            run_frame(8'(n * 7 + 3), 2'(n), 1'b1, 1'b0, acc);
        end
        ifa.in_valid = 1'b0;
        check_val("wrap_frame_cnt", {24'd0, ifa.frame_cnt},     32'd1);
        check_val("wrap_pulses",    32'(done_pulses - pulses0), 32'd257);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
